// File: rtl/l2_snoop_responder.sv
// -----------------------------------------------------------------------------
// l2_snoop_responder
//   Responder side of the shared-bus snoop protocol. Bus operations issued by
//   other caches are queued in a small FIFO. Each one is looked up in the local
//   L2 tag/MESI array, and the snoop result (HIT / HITM / NOHIT) is driven.
//   On HITM the dirty line is flushed. The matching snoop message is then posted
//   to the local MESI FSM.
//
//   Optional build macro: SNOOP_STATS_EN adds saturating result counters
//   (cnt_hit_o, cnt_hitm_o, cnt_nohit_o) and the CNT_W parameter.
//
// Ports
//   clk, rstb          clock, asynchronous active-low reset
//   snp_valid_i/op_i/addr_i/own_i   incoming bus operation
//   snp_ready_o        FIFO not full (registered)
//   lu_req_o/lu_addr_o, lu_ack_i/lu_hit_i/lu_state_i   tag lookup handshake
//   snp_res_valid_o/snp_res_o       one-cycle snoop result strobe
//   flush_req_o/flush_addr_o, flush_done_i             dirty-line write-back
//   nmsg_valid_o/nmsg_o             one-cycle message strobe to the MESI FSM
// -----------------------------------------------------------------------------
module l2_snoop_responder #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
`ifdef SNOOP_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              snp_valid_i,
    input  logic [2:0]        snp_op_i,
    input  logic [ADDR_W-1:0] snp_addr_i,
    input  logic              snp_own_i,
    output logic              snp_ready_o,
    output logic              lu_req_o,
    output logic [ADDR_W-1:0] lu_addr_o,
    input  logic              lu_ack_i,
    input  logic              lu_hit_i,
    input  logic [1:0]        lu_state_i,
    output logic              snp_res_valid_o,
    output logic [1:0]        snp_res_o,
    output logic              flush_req_o,
    output logic [ADDR_W-1:0] flush_addr_o,
    input  logic              flush_done_i,
    output logic              nmsg_valid_o,
    output logic [1:0]        nmsg_o
`ifdef SNOOP_STATS_EN
    ,
    output logic [CNT_W-1:0]  cnt_hit_o,
    output logic [CNT_W-1:0]  cnt_hitm_o,
    output logic [CNT_W-1:0]  cnt_nohit_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_INV   = 3'd3;
    localparam logic [2:0] OP_RWIM  = 3'd4;

    localparam logic [1:0] RES_HIT   = 2'b00;
    localparam logic [1:0] RES_HITM  = 2'b01;
    localparam logic [1:0] RES_NOHIT = 2'b10;

    localparam logic [1:0] MSG_NONE = 2'd0;
    localparam logic [1:0] MSG_RD   = 2'd1;
    localparam logic [1:0] MSG_RDM  = 2'd2;
    localparam logic [1:0] MSG_INV  = 2'd3;

    localparam logic [1:0] MESI_I = 2'd0;
    localparam logic [1:0] MESI_M = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_RESP   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_NOTIFY = 3'd4
    } state_t;

    // Result/message table; returns {snp_res, nmsg}. A tag hit in state I is a miss.
    function automatic logic [3:0] resolve(input logic [2:0] op,
                                           input logic       hit,
                                           input logic [1:0] st);
        logic [1:0] res;
        logic [1:0] msg;
        res = RES_NOHIT;
        msg = MSG_NONE;
        if (hit && (st != MESI_I)) begin
            case (op)
                OP_READ: begin
                    res = (st == MESI_M) ? RES_HITM : RES_HIT;
                    msg = MSG_RD;
                end
                OP_RWIM: begin
                    res = (st == MESI_M) ? RES_HITM : RES_NOHIT;
                    msg = MSG_RDM;
                end
                OP_INV: begin
                    res = RES_NOHIT;
                    msg = MSG_INV;
                end
                OP_WRITE: begin
                    res = RES_NOHIT;
                    msg = MSG_NONE;
                end
                default: begin
                    res = RES_NOHIT;
                    msg = MSG_NONE;
                end
            endcase
        end
        return {res, msg};
    endfunction

    // FIFO storage and pointers (PTR_W+1 bits so full/empty differ in the MSB)
    logic [2:0]        fifo_op_q   [DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic              snp_ready_q;
    logic              op_legal_s, push_s, pop_s, empty_s, full_d;

    // FSM state, working entry and registered outputs
    state_t            state_q;
    logic [2:0]        work_op_q;
    logic [1:0]        msg_q;
    logic              lu_req_q;
    logic [ADDR_W-1:0] lu_addr_q;
    logic              snp_res_valid_q;
    logic [1:0]        snp_res_q;
    logic              flush_req_q;
    logic [ADDR_W-1:0] flush_addr_q;
    logic              nmsg_valid_q;
    logic [1:0]        nmsg_q;
    logic [3:0]        resolved_s;

    // FIFO control: push/pop decode, next pointers, next-cycle full flag
    always_comb begin
        // Codes 5..7 are not defined bus ops and are dropped like NULL.
        op_legal_s = (snp_op_i >= OP_READ) && (snp_op_i <= OP_RWIM);
        push_s     = snp_valid_i & snp_ready_q & ~snp_own_i & op_legal_s;
        empty_s    = (wr_ptr_q == rd_ptr_q);
        pop_s      = (state_q == ST_IDLE) & ~empty_s;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        full_d = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                 (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
        resolved_s = resolve(work_op_q, lu_hit_i, lu_state_i);
    end

    // FIFO storage, pointers and registered ready
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            snp_ready_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_op_q[i]   <= 3'd0;
                fifo_addr_q[i] <= '0;
            end
        end else begin
            if (push_s) begin
                fifo_op_q[wr_ptr_q[PTR_W-1:0]]   <= snp_op_i;
                fifo_addr_q[wr_ptr_q[PTR_W-1:0]] <= snp_addr_i;
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            snp_ready_q <= ~full_d;
        end
    end

    // Snoop sequencer: IDLE -> LOOKUP -> RESP -> [FLUSH] -> [NOTIFY] -> IDLE
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q         <= ST_IDLE;
            work_op_q       <= 3'd0;
            msg_q           <= MSG_NONE;
            lu_req_q        <= 1'b0;
            lu_addr_q       <= '0;
            snp_res_valid_q <= 1'b0;
            snp_res_q       <= RES_NOHIT;
            flush_req_q     <= 1'b0;
            flush_addr_q    <= '0;
            nmsg_valid_q    <= 1'b0;
            nmsg_q          <= MSG_NONE;
        end else begin
            snp_res_valid_q <= 1'b0;
            nmsg_valid_q    <= 1'b0;
            nmsg_q          <= MSG_NONE;
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        work_op_q <= fifo_op_q[rd_ptr_q[PTR_W-1:0]];
                        lu_addr_q <= fifo_addr_q[rd_ptr_q[PTR_W-1:0]];
                        lu_req_q  <= 1'b1;
                        state_q   <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    // Result is registered straight off the ack so it is
                    // visible during RESP.
                    if (lu_ack_i) begin
                        lu_req_q        <= 1'b0;
                        snp_res_valid_q <= 1'b1;
                        snp_res_q       <= resolved_s[3:2];
                        msg_q           <= resolved_s[1:0];
                        state_q         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (snp_res_q == RES_HITM) begin
                        flush_req_q  <= 1'b1;
                        flush_addr_q <= lu_addr_q;
                        state_q      <= ST_FLUSH;
                    end else if (msg_q != MSG_NONE) begin
                        nmsg_valid_q <= 1'b1;
                        nmsg_q       <= msg_q;
                        state_q      <= ST_NOTIFY;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (flush_done_i) begin
                        flush_req_q  <= 1'b0;
                        nmsg_valid_q <= 1'b1;
                        nmsg_q       <= msg_q;
                        state_q      <= ST_NOTIFY;
                    end
                end
                ST_NOTIFY: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    lu_req_q    <= 1'b0;
                    flush_req_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign snp_ready_o     = snp_ready_q;
    assign lu_req_o        = lu_req_q;
    assign lu_addr_o       = lu_addr_q;
    assign snp_res_valid_o = snp_res_valid_q;
    assign snp_res_o       = snp_res_q;
    assign flush_req_o     = flush_req_q;
    assign flush_addr_o    = flush_addr_q;
    assign nmsg_valid_o    = nmsg_valid_q;
    assign nmsg_o          = nmsg_q;

`ifdef SNOOP_STATS_EN
    logic [CNT_W-1:0] cnt_hit_q, cnt_hitm_q, cnt_nohit_q;

    // Saturating per-result counters, updated on each result strobe
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_hit_q   <= '0;
            cnt_hitm_q  <= '0;
            cnt_nohit_q <= '0;
        end else if (snp_res_valid_q) begin
            case (snp_res_q)
                RES_HIT: begin
                    if (cnt_hit_q != {CNT_W{1'b1}}) cnt_hit_q <= cnt_hit_q + 1'b1;
                end
                RES_HITM: begin
                    if (cnt_hitm_q != {CNT_W{1'b1}}) cnt_hitm_q <= cnt_hitm_q + 1'b1;
                end
                RES_NOHIT: begin
                    if (cnt_nohit_q != {CNT_W{1'b1}}) cnt_nohit_q <= cnt_nohit_q + 1'b1;
                end
                default: begin
                    cnt_hit_q <= cnt_hit_q;
                end
            endcase
        end
    end

    assign cnt_hit_o   = cnt_hit_q;
    assign cnt_hitm_o  = cnt_hitm_q;
    assign cnt_nohit_o = cnt_nohit_q;
`endif

endmodule

// File: tb/tb_l2_snoop_responder.sv
module tb_l2_snoop_responder;

    logic        clk = 1'b0;
    logic        rstb;
    logic        snp_valid;
    logic [2:0]  snp_op;
    logic [31:0] snp_addr;
    logic        snp_own;
    logic        snp_ready;
    logic        lu_req;
    logic [31:0] lu_addr;
    logic        lu_ack = 1'b0;
    logic        lu_hit = 1'b0;
    logic [1:0]  lu_state = 2'd0;
    logic        snp_res_valid;
    logic [1:0]  snp_res;
    logic        flush_req;
    logic [31:0] flush_addr;
    logic        flush_done = 1'b0;
    logic        nmsg_valid;
    logic [1:0]  nmsg;
`ifdef SNOOP_STATS_EN
    logic [15:0] cnt_hit, cnt_hitm, cnt_nohit;
`endif

    always #5 clk = ~clk;

    l2_snoop_responder #(.ADDR_W(32), .DEPTH(4)) dut (
        .clk(clk), .rstb(rstb),
        .snp_valid_i(snp_valid), .snp_op_i(snp_op), .snp_addr_i(snp_addr), .snp_own_i(snp_own),
        .snp_ready_o(snp_ready),
        .lu_req_o(lu_req), .lu_addr_o(lu_addr),
        .lu_ack_i(lu_ack), .lu_hit_i(lu_hit), .lu_state_i(lu_state),
        .snp_res_valid_o(snp_res_valid), .snp_res_o(snp_res),
        .flush_req_o(flush_req), .flush_addr_o(flush_addr), .flush_done_i(flush_done),
        .nmsg_valid_o(nmsg_valid), .nmsg_o(nmsg)
`ifdef SNOOP_STATS_EN
        , .cnt_hit_o(cnt_hit), .cnt_hitm_o(cnt_hitm), .cnt_nohit_o(cnt_nohit)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  res;
        logic [1:0]  msg;
        int          t0;
        bit          chk_lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [1:0]  msg_q[$];
    logic [2:0]  tags [logic [31:0]];   // {hit, mesi state}
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          lu_stall = 1'b0;
    bit          flush_stall = 1'b0;
    bit          flush_exp = 1'b0;
    logic [31:0] flush_exp_addr = 32'd0;
    int          flush_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference table: returns {snp_res, nmsg}
    function automatic logic [3:0] model(input logic [2:0] op, input logic [2:0] tag);
        bit       valid_line;
        bit       dirty;
        valid_line = tag[2] && (tag[1:0] != 2'd0);
        dirty      = (tag[1:0] == 2'd3);
        if (!valid_line || op == 3'd2) return {2'b10, 2'd0};
        if (op == 3'd1) return dirty ? {2'b01, 2'd1} : {2'b00, 2'd1};
        if (op == 3'd4) return dirty ? {2'b01, 2'd2} : {2'b10, 2'd2};
        if (op == 3'd3) return {2'b10, 2'd3};
        return {2'b10, 2'd0};
    endfunction

    function automatic logic [2:0] tag_of(input logic [31:0] a);
        if (tags.exists(a)) return tags[a];
        return 3'b000;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard checker plus lookup / flush responders
    always @(negedge clk) begin
        exp_t       e;
        logic [2:0] t;
        if (!rstb) begin
            exp_q.delete();
            msg_q.delete();
            flush_cyc  = 0;
            flush_exp  = 1'b0;
            flush_done = 1'b0;
            lu_ack     = 1'b0;
            lu_hit     = 1'b0;
            lu_state   = 2'd0;
        end else begin
            if (snp_res_valid) begin
                chk("res_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("snp_res@%0h", e.addr), snp_res, e.res);
                    if (e.chk_lat) chk("latency", cyc - e.t0, 3);
                    if (e.msg != 2'd0) msg_q.push_back(e.msg);
                    if (e.res == 2'b01) begin
                        flush_exp      = 1'b1;
                        flush_exp_addr = e.addr;
                    end
                end
            end
            if (nmsg_valid) begin
                chk("nmsg_pending", msg_q.size() != 0, 1);
                if (msg_q.size() != 0) chk("nmsg", nmsg, msg_q.pop_front());
            end
            if (flush_req) begin
                if (flush_cyc == 0) begin
                    chk("flush_expected", flush_exp, 1);
                    chk("flush_addr", flush_addr, flush_exp_addr);
                end
                flush_cyc++;
                flush_done = !flush_stall && (flush_cyc == 2);
            end else begin
                flush_done = 1'b0;
                if (flush_cyc != 0) begin
                    chk("flush_len", flush_cyc, 2);
                    flush_cyc = 0;
                    flush_exp = 1'b0;
                end
            end
            if (lu_req && !lu_stall) begin
                chk("lu_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("lu_addr", lu_addr, exp_q[0].addr);
                t        = tag_of(lu_addr);
                lu_ack   = 1'b1;
                lu_hit   = t[2];
                lu_state = t[1:0];
            end else begin
                lu_ack   = 1'b0;
                lu_hit   = 1'b0;
                lu_state = 2'd0;
            end
        end
    end

    // Drive one bus op for one cycle; called just after a rising edge
    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic own,
                        input bit acc, input bit lat);
        exp_t       e;
        logic [3:0] m;
        m         = model(op, tag_of(addr));
        snp_valid = 1'b1;
        snp_op    = op;
        snp_addr  = addr;
        snp_own   = own;
        if (acc) begin
            e.addr    = addr;
            e.res     = m[3:2];
            e.msg     = m[1:0];
            e.t0      = cyc;
            e.chk_lat = lat;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        snp_valid = 1'b0;
        snp_op    = 3'd0;
        snp_own   = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || msg_q.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_drain"}, n < 200, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rstb      = 1'b0;
        snp_valid = 1'b0;
        snp_op    = 3'd0;
        snp_addr  = 32'd0;
        snp_own   = 1'b0;
        tags[32'h100] = 3'b111;  // M
        tags[32'h200] = 3'b101;  // S
        tags[32'h300] = 3'b110;  // E
        tags[32'h400] = 3'b111;  // M
        tags[32'h500] = 3'b100;  // tag hit but I
        tags[32'h600] = 3'b110;  // E
        tags[32'h700] = 3'b101;
        tags[32'h710] = 3'b111;
        tags[32'h730] = 3'b110;
        tags[32'h740] = 3'b100;
        tags[32'h750] = 3'b111;
        tags[32'h800] = 3'b111;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", snp_ready, 1);
        chk("rst_res", snp_res, 2);
        chk("rst_res_valid", snp_res_valid, 0);
        chk("rst_lu_req", lu_req, 0);
        chk("rst_flush_req", flush_req, 0);
        chk("rst_nmsg_valid", nmsg_valid, 0);
        @(negedge clk); rstb = 1'b1;
        @(posedge clk); #1;

        // READ hitting M: HITM, 2-cycle flush, then SNOOP_READ_REQ
        send(3'd1, 32'h100, 1'b0, 1'b1, 1'b1);
        drain("read_m");
        // RWIM hitting S
        send(3'd4, 32'h200, 1'b0, 1'b1, 1'b0);
        drain("rwim_s");
        // INVALIDATE on E followed by WRITE on M
        send(3'd3, 32'h300, 1'b0, 1'b1, 1'b0);
        send(3'd2, 32'h400, 1'b0, 1'b1, 1'b0);
        drain("inv_write");
        // Miss via state I, READ hit E, plain miss
        send(3'd1, 32'h500, 1'b0, 1'b1, 1'b0);
        send(3'd1, 32'h600, 1'b0, 1'b1, 1'b0);
        send(3'd1, 32'h900, 1'b0, 1'b1, 1'b0);
        drain("misc");
        // Own op and NULL op are never queued
        send(3'd1, 32'hA00, 1'b1, 1'b0, 1'b0);
        send(3'd0, 32'hA10, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("own_null_lu_req", lu_req, 0);
        chk("own_null_ready", snp_ready, 1);

        // Overflow with the lookup stalled: the 6th op is lost
        lu_stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("ready_before_%0d", i), snp_ready, (i < 5) ? 1 : 0);
            send(3'd1, 32'h700 + 32'(i) * 32'h10, 1'b0, i < 5, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("ready_full", snp_ready, 0);
        lu_stall = 1'b0;
        drain("overflow");
        chk("ready_after_drain", snp_ready, 1);

        // Reset in the middle of a flush
        flush_stall = 1'b1;
        send(3'd1, 32'h800, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (!flush_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("flush_seen", flush_req, 1);
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rstb = 1'b0;
        #1;
        chk("midrst_flush_req", flush_req, 0);
        chk("midrst_ready", snp_ready, 1);
        chk("midrst_lu_req", lu_req, 0);
        @(negedge clk); #2;
        rstb = 1'b1;
        flush_stall = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_nmsg_valid", nmsg_valid, 0);
        chk("post_rst_flush_req", flush_req, 0);
        chk("final_queues", exp_q.size() + msg_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
